heartbeat_meter: RTL and testbench
==================================

Name: heartbeat_meter

Overview:
- Parametrised successor of the heart-rhythm input block. It measures the clk-cycle interval between heartbeat pulses on an asynchronous input.
- Rejects glitches inside a refractory window and detects loss of signal.
- Keeps a running average over the last 2^AVG_LOG2 intervals and publishes a scaled, saturated value on a slow update strobe.
- Sits in the input stage and feeds the rhythm/display logic.

Parameters:
- CNT_W, 25, width of the interval counter (saturating).
- SHIFT, 16, right-shift applied to the raw interval before averaging.
- OUT_W, 8, width of the published interval value.
- AVG_LOG2, 2, log2 of the averaging depth (depth = 4).
- MIN_GAP, 2**20, refractory cycles; beats arriving with count < MIN_GAP are ignored.
- TIMEOUT, 2**24, count value at which loss of signal is declared (TIMEOUT < 2**CNT_W).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- beat_in  in  1  asynchronous heartbeat pulse; its rising edge is a beat.
- tick  in  1  single-cycle, clk-synchronous publish strobe (replaces the old slow clock).
- beat_pulse  out  1  one-cycle pulse per accepted beat.
- interval_out  out  OUT_W  published averaged interval.
- valid  out  1  the averaging buffer holds 2^AVG_LOG2 samples.
- timeout  out  1  sticky loss-of-signal flag, cleared by the next accepted beat.

Behaviour:
- Reset (async) values:
  - All outputs are 0.
  - count = 0, sum = 0, fill = 0, sample buffer = 0, state = IDLE.
  - Both synchronizer flops are 0.
- Input conditioning:
  - 2-flop synchronizer followed by a registered previous value.
  - evt = sync2 & ~prev.
  - A beat_in rise is seen as evt 2–3 cycles after the edge.
  - A level held high produces exactly one evt.
- Counter:
  - Increments every cycle and saturates at 2^CNT_W-1 (no wrap).
  - Set to 0 in any cycle with an accepted beat.
- Acceptance: accepted = evt & (state==IDLE | count >= MIN_GAP). A non-accepted evt has no effect at all; the count continues.
- States:
  - IDLE: waiting for the first beat. An accepted beat → MEASURE and zeroes count; no sample is taken.
  - MEASURE, on an accepted beat:
    - sample = min(count >> SHIFT, 2^OUT_W-1).
    - The sample is written into the ring slot at wr_ptr, and sum += sample - old_slot.
    - wr_ptr wraps modulo 2^AVG_LOG2.
    - fill increments, saturating at 2^AVG_LOG2; valid = (fill == 2^AVG_LOG2).
  - MEASURE, when count == TIMEOUT with no accepted beat that cycle:
    - timeout <= 1; buffer, sum, fill, wr_ptr and valid are cleared.
    - state → IDLE; count keeps running (saturating).
- An accepted beat in the same cycle as count==TIMEOUT wins; no timeout is raised.
- An accepted beat in IDLE clears timeout.
- beat_pulse is registered: high the cycle after the accepted cycle.
- Sum width is OUT_W+AVG_LOG2. Average = sum >> AVG_LOG2 (truncating).
- Publish: on tick, interval_out <= valid ? average : 0.
  - tick coinciding with an accepted beat publishes the pre-update average.
  - tick coinciding with a timeout publishes the pre-clear value.
  - interval_out holds between ticks.
- Reset mid-operation returns everything to reset values immediately. Any pending beat is lost.

Decomposition:
- Package heartbeat_pkg contains:
  - state enum {IDLE, MEASURE}.
  - The saturate-to-OUT_W function.
  - Default parameter constants.
- Sub-module beat_sync_edge: 2-flop synchronizer plus rising-edge detector with async reset, outputting evt. It is reused by other pulse inputs.
- Averaging ring, counter and FSM remain in heartbeat_meter.

Test Plan:
Test parameters: SHIFT=0, OUT_W=8, AVG_LOG2=2, MIN_GAP=8, TIMEOUT=200.
- Steady rhythm: beat_in rising every 20 cycles, 5 beats, then tick → valid=1, interval_out=20; beat_pulse fires 5 times.
- Rate step: continue with beats every 40 cycles; tick after the first 40-cycle interval → 25; after four such intervals → 40.
- Glitch: an extra beat_in rise 3 cycles after an accepted beat → ignored, no beat_pulse; the next interval still measures 20.
- Loss of signal: stop beats for >200 cycles → timeout=1, valid=0; next tick → interval_out=0. Then the next beat clears timeout, and valid returns after 4 more intervals.
- Saturation/priority: TIMEOUT=1000 with one interval of 300 → that sample = 255. A tick in the same cycle as an accepted beat publishes the old average.
- Reset mid-MEASURE: assert reset for 1 cycle asynchronously → all outputs 0 immediately; the first subsequent beat produces no sample.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// ---------------------------------------------------------------------------
// heartbeat_pkg
// Shared types, default parameter values and helpers for the heartbeat input
// stage.
//   - hb_state_e   : measurement FSM states (IDLE, MEASURE)
//   - DEF_*        : default parameter values of heartbeat_meter
//   - sat_unsigned : clamps an unsigned value to the largest value of a width
// ---------------------------------------------------------------------------
package heartbeat_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } hb_state_e;

    localparam int unsigned DEF_CNT_W    = 25;
    localparam int unsigned DEF_SHIFT    = 16;
    localparam int unsigned DEF_OUT_W    = 8;
    localparam int unsigned DEF_AVG_LOG2 = 2;
    localparam int unsigned DEF_MIN_GAP  = 2 ** 20;
    localparam int unsigned DEF_TIMEOUT  = 2 ** 24;

    // Clamp value to 2^width-1 (width must be below 64).
    function automatic logic [63:0] sat_unsigned(input logic [63:0] value,
                                                 input int unsigned width);
        logic [63:0] limit;
        limit = (64'd1 << width) - 64'd1;
        if (value > limit) begin
            return limit;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/beat_sync_edge.sv
// ---------------------------------------------------------------------------
// beat_sync_edge
// Two-flop synchronizer for an asynchronous pulse input followed by a
// registered previous value; evt is high for one cycle per rising edge seen
// after synchronization (2-3 cycles after the input edge). A level held high
// yields exactly one evt.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high reset
//   din   in  asynchronous input
//   evt   out one-cycle rising-edge event, clk-synchronous
// ---------------------------------------------------------------------------
module beat_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic evt
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain and previous-value register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign evt = sync2_r & ~prev_r;

endmodule

// File: rtl/heartbeat_meter.sv
// ---------------------------------------------------------------------------
// heartbeat_meter
// Measures the clk-cycle interval between heartbeat pulses on an asynchronous
// input, rejects glitches inside a refractory window, detects loss of signal
// and keeps a running average over the last 2^AVG_LOG2 intervals. The scaled,
// saturated average is published on each tick strobe.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous, active-high reset
//   beat_in      in  asynchronous heartbeat pulse (rising edge = beat)
//   tick         in  one-cycle publish strobe
//   beat_pulse   out one-cycle pulse per accepted beat (registered)
//   interval_out out published averaged interval (OUT_W bits)
//   valid        out averaging buffer holds 2^AVG_LOG2 samples
//   timeout      out sticky loss-of-signal flag, cleared by next accepted beat
// ---------------------------------------------------------------------------
module heartbeat_meter
    import heartbeat_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned SHIFT    = DEF_SHIFT,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
    parameter int unsigned MIN_GAP  = DEF_MIN_GAP,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat_in,
    input  logic             tick,
    output logic             beat_pulse,
    output logic [OUT_W-1:0] interval_out,
    output logic             valid,
    output logic             timeout
);

    localparam int unsigned DEPTH = 2 ** AVG_LOG2;
    localparam int unsigned SUM_W = OUT_W + AVG_LOG2;

    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]    MIN_GAP_C = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1'b1);
    localparam logic [AVG_LOG2:0]   FILL_ONE  = (AVG_LOG2 + 1)'(1'b1);
    localparam logic [AVG_LOG2:0]   FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};

    logic                evt_s;
    logic                accepted_s;
    logic                take_sample_s;
    logic                clear_s;
    logic                timeout_hit_s;
    hb_state_e           state_r;
    hb_state_e           state_nxt_s;

    logic [CNT_W-1:0]    count_r;
    logic [CNT_W:0]      interval_s;
    logic [OUT_W-1:0]    sample_s;
    logic [OUT_W-1:0]    old_slot_s;
    logic [SUM_W-1:0]    sum_r;
    logic [SUM_W-1:0]    sum_nxt_s;
    logic [OUT_W-1:0]    average_s;
    logic [AVG_LOG2:0]   fill_r;
    logic [AVG_LOG2:0]   fill_nxt_s;
    logic [AVG_LOG2-1:0] wr_ptr_r;
    logic [OUT_W-1:0]    ring_r [DEPTH];

    logic                beat_pulse_r;
    logic [OUT_W-1:0]    interval_out_r;
    logic                valid_r;
    logic                timeout_r;

    beat_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (beat_in),
        .evt   (evt_s)
    );

    // Refractory window only applies while measuring; the first beat is always taken.
    assign accepted_s = evt_s & ((state_r == IDLE) | (count_r >= MIN_GAP_C));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and datapath controls; an accepted beat beats a timeout.
    always_comb begin
        state_nxt_s   = state_r;
        take_sample_s = 1'b0;
        clear_s       = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accepted_s) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEASURE: begin
                if (accepted_s) begin
                    take_sample_s = 1'b1;
                end else if (count_r == TIMEOUT_C) begin
                    timeout_hit_s = 1'b1;
                    clear_s       = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = MEASURE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // The counter restarts at 0 in the cycle after an accepted beat, so the
    // number of cycles between two beats is count + 1 at the second beat.
    // The extra bit keeps the saturated count from wrapping.
    always_comb begin
        interval_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
        sample_s   = OUT_W'(sat_unsigned(64'(interval_s >> SHIFT), OUT_W));
        old_slot_s = ring_r[wr_ptr_r];
        sum_nxt_s  = sum_r + SUM_W'(sample_s) - SUM_W'(old_slot_s);
        average_s  = OUT_W'(sum_r >> AVG_LOG2);
        if (fill_r == FILL_FULL) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FILL_ONE;
        end
    end

    // Saturating interval counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (accepted_s) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Averaging ring, running sum, fill level and valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_r[i] <= {OUT_W{1'b0}};
            end
            sum_r    <= {SUM_W{1'b0}};
            fill_r   <= {(AVG_LOG2 + 1){1'b0}};
            wr_ptr_r <= {AVG_LOG2{1'b0}};
            valid_r  <= 1'b0;
        end else if (take_sample_s) begin
            ring_r[wr_ptr_r] <= sample_s;
            sum_r            <= sum_nxt_s;
            fill_r           <= fill_nxt_s;
            wr_ptr_r         <= wr_ptr_r + PTR_ONE;
            valid_r          <= (fill_nxt_s == FILL_FULL);
        end else if (clear_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_r[i] <= {OUT_W{1'b0}};
            end
            sum_r    <= {SUM_W{1'b0}};
            fill_r   <= {(AVG_LOG2 + 1){1'b0}};
            wr_ptr_r <= {AVG_LOG2{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            sum_r    <= sum_r;
            fill_r   <= fill_r;
            wr_ptr_r <= wr_ptr_r;
            valid_r  <= valid_r;
        end
    end

    // Sticky loss-of-signal flag and accepted-beat pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_r    <= 1'b0;
            beat_pulse_r <= 1'b0;
        end else begin
            beat_pulse_r <= accepted_s;
            if (accepted_s) begin
                timeout_r <= 1'b0;
            end else if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Publish register; reads pre-update sum/valid so a coincident beat or
    // timeout does not affect the value published in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interval_out_r <= {OUT_W{1'b0}};
        end else if (tick) begin
            interval_out_r <= valid_r ? average_s : {OUT_W{1'b0}};
        end else begin
            interval_out_r <= interval_out_r;
        end
    end

    assign beat_pulse   = beat_pulse_r;
    assign interval_out = interval_out_r;
    assign valid        = valid_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_heartbeat_meter.sv
// ---------------------------------------------------------------------------
// tb_heartbeat_meter
// Self-checking bench for heartbeat_meter. Main instance: SHIFT=0, OUT_W=8,
// AVG_LOG2=2, MIN_GAP=8, TIMEOUT=200. Second instance with TIMEOUT=1000 for
// the saturation / tick-priority scenario. Published values are predicted
// from the beat spacing the bench drives, queued when tick is driven and
// compared when interval_out updates.
// ---------------------------------------------------------------------------
module tb_heartbeat_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       beat_in;
    logic       tick;
    logic       beat_pulse;
    logic [7:0] interval_out;
    logic       valid;
    logic       timeout;

    logic       reset2;
    logic       beat2;
    logic       tick2;
    logic       beat_pulse2;
    logic [7:0] interval_out2;
    logic       valid2;
    logic       timeout2;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    // bench model of the averaging buffer
    int ring_m[$];
    bit meas_m   = 1'b0;
    int prev_gap = 0;

    always #5 clk = ~clk;

    heartbeat_meter #(
        .CNT_W(25), .SHIFT(0), .OUT_W(8), .AVG_LOG2(2), .MIN_GAP(8), .TIMEOUT(200)
    ) dut (
        .clk(clk), .reset(reset), .beat_in(beat_in), .tick(tick),
        .beat_pulse(beat_pulse), .interval_out(interval_out),
        .valid(valid), .timeout(timeout)
    );

    heartbeat_meter #(
        .CNT_W(25), .SHIFT(0), .OUT_W(8), .AVG_LOG2(2), .MIN_GAP(8), .TIMEOUT(1000)
    ) dut_sat (
        .clk(clk), .reset(reset2), .beat_in(beat2), .tick(tick2),
        .beat_pulse(beat_pulse2), .interval_out(interval_out2),
        .valid(valid2), .timeout(timeout2)
    );

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int model_avg();
        int s;
        s = 0;
        if (ring_m.size() < 4) return 0;
        foreach (ring_m[i]) s += ring_m[i];
        return s / 4;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // count accepted-beat pulses of the main instance
    initial forever begin
        @(posedge clk);
        if (beat_pulse === 1'b1) pulses++;
    end

    // scoreboard drain: main instance
    initial forever begin
        @(posedge clk);
        if (tick === 1'b1 && reset === 1'b0) begin
            logic [7:0] e;
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL publish_unexpected: interval_out=%0d with no queued expectation", interval_out);
            end else begin
                e = exp_q.pop_front();
                if (interval_out !== e) begin
                    errors++;
                    $display("FAIL publish: interval_out=%0d expected %0d", interval_out, e);
                end
            end
        end
    end

    // scoreboard drain: saturation instance
    initial forever begin
        @(posedge clk);
        if (tick2 === 1'b1 && reset2 === 1'b0) begin
            logic [7:0] e;
            #1;
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL publish2_unexpected: interval_out=%0d with no queued expectation", interval_out2);
            end else begin
                e = exp2_q.pop_front();
                if (interval_out2 !== e) begin
                    errors++;
                    $display("FAIL publish2: interval_out=%0d expected %0d", interval_out2, e);
                end
            end
        end
    end

    // one tick on the main instance with the model's expectation queued
    task automatic publish();
        exp_q.push_back(8'(model_avg()));
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    // rising edge on beat_in, then gap cycles until the next rise is allowed;
    // optional tick once the beat has been absorbed
    task automatic beat_then(input int gap, input bit do_tick);
        beat_in = 1'b1;
        if (meas_m) begin
            ring_m.push_back(sat8(prev_gap));
            if (ring_m.size() > 4) void'(ring_m.pop_front());
        end
        meas_m   = 1'b1;
        prev_gap = gap;
        cyc(2);
        beat_in = 1'b0;
        cyc(3);
        if (do_tick) begin
            publish();
            cyc(gap - 6);
        end else begin
            cyc(gap - 5);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; beat_in = 1'b0; tick = 1'b0;
        reset2 = 1'b1; beat2 = 1'b0; tick2 = 1'b0;
        cyc(3);
        checks++; if (beat_pulse !== 1'b0) begin errors++; $display("FAIL reset_beat_pulse: got %b want 0", beat_pulse); end
        checks++; if (interval_out !== 8'd0) begin errors++; $display("FAIL reset_interval: got %0d want 0", interval_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_steady();
        int p0;
        p0 = pulses;
        repeat (4) beat_then(20, 1'b0);
        beat_then(40, 1'b1);                  // 4 intervals of 20 -> 20
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL steady_valid: got %b want 1", valid); end
        checks++; if (pulses - p0 !== 5) begin errors++; $display("FAIL steady_pulses: got %0d want 5", pulses - p0); end
    endtask

    task automatic test_rate_step();
        beat_then(40, 1'b1);                  // 20,20,20,40 -> 25
        beat_then(40, 1'b0);
        beat_then(40, 1'b0);
        beat_then(20, 1'b1);                  // 40,40,40,40 -> 40
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rate_valid: got %b want 1", valid); end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses;
        beat_in = 1'b1;
        ring_m.push_back(sat8(prev_gap));
        if (ring_m.size() > 4) void'(ring_m.pop_front());
        prev_gap = 20;
        cyc(2);
        beat_in = 1'b0;
        cyc(1);
        beat_in = 1'b1;                       // second rise 3 cycles later
        cyc(2);
        beat_in = 1'b0;
        cyc(15);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", pulses - p0); end
        beat_then(20, 1'b1);                  // 40,40,20,20 -> 30
    endtask

    task automatic test_loss();
        cyc(250);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL loss_timeout: got %b want 1", timeout); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL loss_valid: got %b want 0", valid); end
        ring_m.delete();
        meas_m = 1'b0;
        publish();                            // not valid -> 0
        beat_then(20, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL loss_clear: got %b want 0", timeout); end
        repeat (3) beat_then(20, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL loss_valid3: got %b want 0", valid); end
        beat_then(20, 1'b1);                  // 4 intervals of 20 -> 20
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL loss_valid4: got %b want 1", valid); end
    endtask

    task automatic test_reset_mid();
        int p0;
        beat_then(20, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (beat_pulse !== 1'b0) begin errors++; $display("FAIL mid_beat_pulse: got %b want 0", beat_pulse); end
        checks++; if (interval_out !== 8'd0) begin errors++; $display("FAIL mid_interval: got %0d want 0", interval_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL mid_timeout: got %b want 0", timeout); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        ring_m.delete();
        meas_m = 1'b0;
        p0 = pulses;
        beat_then(20, 1'b0);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL mid_first_pulse: got %0d want 1", pulses - p0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid_first: got %b want 0", valid); end
        beat_then(20, 1'b1);                  // one sample only -> 0
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid_second: got %b want 0", valid); end
    endtask

    task automatic beat2_gap(input int gap);
        beat2 = 1'b1;
        cyc(2);
        beat2 = 1'b0;
        cyc(gap - 2);
    endtask

    task automatic test_saturation();
        reset2 = 1'b0;
        cyc(2);
        beat2_gap(300);                       // first beat, IDLE
        beat2_gap(20);                        // sample 300 -> 255
        beat2_gap(20);
        beat2_gap(20);
        beat2 = 1'b1;                         // 4th sample: 255,20,20,20
        cyc(2);
        beat2 = 1'b0;
        cyc(3);
        exp2_q.push_back(8'd78);              // (255+60)/4
        tick2 = 1'b1;
        cyc(1);
        tick2 = 1'b0;
        cyc(14);
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", valid2); end
        // tick in the same cycle as the accepted beat publishes the old average
        beat2 = 1'b1;
        cyc(2);
        tick2 = 1'b1;
        exp2_q.push_back(8'd78);
        cyc(1);
        tick2 = 1'b0;
        beat2 = 1'b0;
        cyc(2);
        exp2_q.push_back(8'd20);              // ring now 20,20,20,20
        tick2 = 1'b1;
        cyc(1);
        tick2 = 1'b0;
        cyc(2);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_steady();
        test_rate_step();
        test_glitch();
        test_loss();
        test_reset_mid();
        test_saturation();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d publishes missing want 0", exp_q.size()); end
        checks++; if (exp2_q.size() != 0) begin errors++; $display("FAIL drain2: %0d publishes missing want 0", exp2_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
